multiplier_seq: RTL and testbench

Sequential, parametrised multiplier that replaces the combinational multiplier wherever area matters more than latency. It computes one partial product per clock using shift-and-add, supports unsigned and two's-complement operands selected per operation, and uses a start/busy/done handshake so a controller or datapath FSM can issue back-to-back multiplies. The product is registered and held until the next operation completes.

---
 rtl/multiplier_seq.sv | 105 ++++++++++
 tb/tb_multiplier_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// Sequential shift-and-add multiplier: one partial product per clock, unsigned or
// two's-complement operands, start/busy/done handshake with a held registered product.
module multiplier_seq #(
  parameter int unsigned p_width = 6
) (
  input  logic                   i_w_clk,
  input  logic                   i_w_reset,
  input  logic                   i_w_start,
  input  logic                   i_w_signed,
  input  logic [p_width-1:0]     i_w_a,
  input  logic [p_width-1:0]     i_w_b,
  output logic [2*p_width-1:0]   o_w_p,
  output logic                   o_w_busy,
  output logic                   o_w_done
);

  localparam int unsigned PW = 2 * p_width;
  localparam int unsigned CW = $clog2(p_width) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PW-1:0]      mcand;
  logic [p_width-1:0] mplier;
  logic [PW-1:0]      acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               accept_c;
  logic               last_c;
  logic [p_width-1:0] mag_a_c;
  logic [p_width-1:0] mag_b_c;
  logic [PW-1:0]      acc_sum_c;
  logic [PW-1:0]      prod_c;

  // Operand magnitudes; the most-negative value maps cleanly onto 2^(p_width-1).
  always_comb begin
    mag_a_c = i_w_a;
    mag_b_c = i_w_b;
    if (i_w_signed && i_w_a[p_width-1]) mag_a_c = -i_w_a;
    if (i_w_signed && i_w_b[p_width-1]) mag_b_c = -i_w_b;
  end

  // Accumulator including the current partial product, plus the sign-corrected result.
  always_comb begin
    accept_c  = i_w_start && (state != RUN);
    last_c    = (cnt == CW'(p_width - 1));
    acc_sum_c = acc + (mplier[0] ? mcand : '0);
    prod_c    = neg ? -acc_sum_c : acc_sum_c;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_w_start) state_nxt = RUN;
      RUN:     if (last_c)    state_nxt = DONE;
      DONE:    state_nxt = i_w_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and handshake flags, derived from the next state so they stay registered.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state    <= IDLE;
      o_w_busy <= 1'b0;
      o_w_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_w_busy <= (state_nxt == RUN);
      o_w_done <= (state_nxt == DONE);
    end
  end

  // Datapath: latch on accept, iterate in RUN, publish the product on the last iteration.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      o_w_p  <= '0;
    end else if (accept_c) begin
      mcand  <= PW'(mag_a_c);
      mplier <= mag_b_c;
      acc    <= '0;
      cnt    <= '0;
      neg    <= i_w_signed && (i_w_a[p_width-1] ^ i_w_b[p_width-1]);
    end else if (state == RUN) begin
      acc    <= acc_sum_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_c) o_w_p <= prod_c;
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed/table-driven bench for multiplier_seq at p_width 6, with 2- and 16-bit instances
// sharing the stimulus buses for the width sweep.
module tb_multiplier_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [15:0] a_bus;
  logic [15:0] b_bus;

  logic [3:0]  p2;
  logic        busy2, done2;
  logic [11:0] p6;
  logic        busy6, done6;
  logic [31:0] p16;
  logic        busy16, done16;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multiplier_seq #(.p_width(6)) dut6 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_start(start), .i_w_signed(sgn),
    .i_w_a(a_bus[5:0]), .i_w_b(b_bus[5:0]),
    .o_w_p(p6), .o_w_busy(busy6), .o_w_done(done6)
  );

  multiplier_seq #(.p_width(2)) dut2 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_start(start), .i_w_signed(sgn),
    .i_w_a(a_bus[1:0]), .i_w_b(b_bus[1:0]),
    .o_w_p(p2), .o_w_busy(busy2), .o_w_done(done2)
  );

  multiplier_seq #(.p_width(16)) dut16 (
    .i_w_clk(clk), .i_w_reset(reset), .i_w_start(start), .i_w_signed(sgn),
    .i_w_a(a_bus), .i_w_b(b_bus),
    .o_w_p(p16), .o_w_busy(busy16), .o_w_done(done16)
  );

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic        s;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic done_of(input int w);
    if (w == 2) return done2;
    if (w == 16) return done16;
    return done6;
  endfunction

  function automatic logic busy_of(input int w);
    if (w == 2) return busy2;
    if (w == 16) return busy16;
    return busy6;
  endfunction

  function automatic logic [31:0] p_of(input int w);
    if (w == 2) return 32'(p2);
    if (w == 16) return p16;
    return 32'(p6);
  endfunction

  // Reference product: sign/zero-extend, multiply in 64 bits, keep 2*w bits.
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    longint ea, eb, m;
    m  = (64'sd1 <<< w) - 1;
    ea = longint'(a) & m;
    eb = longint'(b) & m;
    if (s && ea >= (64'sd1 <<< (w - 1))) ea = ea - (64'sd1 <<< w);
    if (s && eb >= (64'sd1 <<< (w - 1))) eb = eb - (64'sd1 <<< w);
    return 32'((ea * eb) & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  // One start pulse; lat counts cycles from the accept edge to the done cycle (bounded).
  task automatic do_mul(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [31:0] p, output int lat);
    @(negedge clk);
    start = 1'b1; a_bus = a; b_bus = b; sgn = s;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done_of(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = p_of(w);
  endtask

  initial begin
    logic [31:0] p;
    int lat;
    int k;
    logic seen;

    vecs[0]  = '{6'h20, 6'h20, 1'b1, 12'h400};
    vecs[1]  = '{6'h20, 6'h1F, 1'b1, 12'hC20};
    vecs[2]  = '{6'h3F, 6'h01, 1'b1, 12'hFFF};
    vecs[3]  = '{6'h00, 6'h20, 1'b1, 12'h000};
    vecs[4]  = '{6'h05, 6'h3D, 1'b1, 12'hFF1};
    vecs[5]  = '{6'h3F, 6'h3F, 1'b0, 12'hF81};
    vecs[6]  = '{6'h20, 6'h20, 1'b0, 12'h400};
    vecs[7]  = '{6'h07, 6'h09, 1'b0, 12'h03F};
    vecs[8]  = '{6'h3F, 6'h3F, 1'b1, 12'h001};
    vecs[9]  = '{6'h1F, 6'h1F, 1'b1, 12'h3C1};
    vecs[10] = '{6'h00, 6'h00, 1'b0, 12'h000};
    vecs[11] = '{6'h2A, 6'h02, 1'b0, 12'h054};

    reset = 1'b1; start = 1'b0; sgn = 1'b0; a_bus = '0; b_bus = '0;
    repeat (2) @(negedge clk);
    check("reset_p", 32'(p6), 32'h0);
    check("reset_busy", 32'(busy6), 32'h0);
    check("reset_done", 32'(done6), 32'h0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy6 || done6 || p6 != 12'h0) seen = 1'b1;
    end
    check("idle_no_activity", 32'(seen), 32'h0);

    // Signed and unsigned corners from the table.
    for (int i = 0; i < 12; i++) begin
      do_mul(6, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].s, p, lat);
      check($sformatf("vec%0d_p", i), p, 32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd7);
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy6), 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), 32'(done6), 32'h0);
      check($sformatf("vec%0d_p_held", i), 32'(p6), 32'(vecs[i].exp));
    end

    // Back-to-back with start held; operand changes during RUN must not disturb the first op.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a_bus = 16'd3; b_bus = 16'd4;
    @(negedge clk);
    check("b2b_busy", 32'(busy6), 32'h1);
    a_bus = 16'd7; b_bus = 16'd9;
    k = 1;
    while (!done6 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_p", 32'(p6), 32'd12);
    check("b2b_first_lat", 32'(k), 32'd7);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done6 && k < 40);
    check("b2b_second_p", 32'(p6), 32'd63);
    check("b2b_spacing", 32'(k), 32'd7);
    start = 1'b0;
    @(negedge clk);
    check("b2b_idle_after", 32'({busy6, done6}), 32'h0);

    // Reset in the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; a_bus = 16'd10; b_bus = 16'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_p", 32'(p6), 32'h0);
    check("abort_busy", 32'(busy6), 32'h0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done6) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'h0);
    do_mul(6, 16'd2, 16'd3, 1'b0, p, lat);
    check("after_abort_p", p, 32'd6);
    check("after_abort_lat", 32'(lat), 32'd7);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a_bus = 16'd5; b_bus = 16'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset_over_start", 32'({busy6, done6}), 32'h0);
    repeat (20) @(negedge clk);

    // Unsigned exhaustive at width 6.
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) begin
        do_mul(6, 16'(ia), 16'(ib), 1'b0, p, lat);
        check($sformatf("u6_%0dx%0d", ia, ib), {p[31:16], p[15:0]} | 32'(lat != 7) << 31,
              32'(ia * ib));
      end
    end

    // Width sweep: dut16 may still be iterating, so let it drain first.
    repeat (20) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'(i % 2);
      do_mul(2, ra, rb, rs, p, lat);
      check($sformatf("w2_%0d_p", i), p, model(2, ra, rb, rs));
      check($sformatf("w2_%0d_lat", i), 32'(lat), 32'd3);
      repeat (20) @(negedge clk);
      do_mul(16, ra, rb, rs, p, lat);
      check($sformatf("w16_%0d_p", i), p, model(16, ra, rb, rs));
      check($sformatf("w16_%0d_lat", i), 32'(lat), 32'd17);
      check($sformatf("w16_%0d_busy_at_done", i), 32'(busy_of(16)), 32'h0);
    end
    do_mul(16, 16'h8000, 16'h8000, 1'b1, p, lat);
    check("w16_minmin", p, 32'h4000_0000);
    do_mul(16, 16'hFFFF, 16'hFFFF, 1'b0, p, lat);
    check("w16_umax", p, 32'hFFFE_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
